// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory (combinational read, clocked write)
// between the instruction-fetch port (I, read-only) and the load/store port
// (D). Every access walks IDLE -> ACCESS -> DONE. Ties are broken round-robin.
//
// Handshake: a requester raises req with addr/we/wdata and holds all of them
// stable until it sees its one-cycle ack. req is only sampled in IDLE. If req
// is still high in the IDLE cycle that follows ack, it is a new request.
// rdata/err are meaningful only while ack=1. rdata holds its value afterwards.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Port id encoding used for lat_port and last_grant.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t        state;
  state_t        state_nxt;
  logic          lat_port;
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [DW-1:0] lat_wdata;
  logic          last_grant;
  logic [DW-1:0] i_resp;
  logic [DW-1:0] d_resp;
  logic          any_req;
  logic          grant_d;
  logic          aligned;
  logic [DW-1:0] capture;

  assign aligned  = (lat_addr[1:0] == 2'b00);
  assign mem_addr = lat_addr;
  assign mem_wd   = lat_wdata;
  assign i_rdata  = i_resp;
  assign d_rdata  = d_resp;

  // Arbitration: a lone request wins; on a tie the port opposite last_grant wins.
  always_comb begin
    any_req = i_req | d_req;
    grant_d = d_req & (~i_req | (last_grant == PORT_I));
    capture = (lat_we | ~aligned) ? '0 : mem_rd;
  end

  // State register; reset returns to IDLE at once so mem_we drops immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_err     = 1'b0;
    d_err     = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_we    = lat_we & aligned;
        state_nxt = DONE;
      end
      DONE: begin
        i_ack     = (lat_port == PORT_I);
        d_ack     = (lat_port == PORT_D);
        i_err     = (lat_port == PORT_I) & ~aligned;
        d_err     = (lat_port == PORT_D) & ~aligned;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch on grant, response capture in ACCESS, fairness update in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_port   <= PORT_I;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      last_grant <= PORT_D;
      i_resp     <= '0;
      d_resp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (grant_d) begin
              lat_port  <= PORT_D;
              lat_addr  <= d_addr;
              lat_we    <= d_we;
              lat_wdata <= d_wdata;
            end else begin
              lat_port  <= PORT_I;
              lat_addr  <= i_addr;
              lat_we    <= 1'b0;
              lat_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (lat_port == PORT_D) d_resp <= capture;
          else                    i_resp <= capture;
        end
        DONE: begin
          last_grant <= lat_port;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, table-driven single accesses,
// hand-written corner sequences and a randomized run against a
// transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 1) return 32'h2008_0005;
    return 32'hA500_0000 | (i * 32'h0001_0101);
  endfunction

  // Unified memory: 64 words, combinational read, clocked write.
  logic [DW-1:0] mem [0:63];
  logic          init_mem = 1'b0;
  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wd;
    end
  end

  // Reference memory contents, updated by the bench's own model.
  logic [31:0] ref_mem [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic full_reset();
    reset_n  = 1'b0;
    i_req    = 1'b0; i_addr = '0;
    d_req    = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    init_mem = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    reset_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wd"}, mem_wd, 32'h0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_flags"}, {26'h0, i_ack, d_ack, i_err, d_err, mem_we, busy}, 32'h0);
  endtask

  typedef struct {
    logic        port;   // 0 = I, 1 = D
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  // Single access on one port; checks latency, data, err, write count, no stray ack.
  task automatic do_access(input vec_t v, input int idx);
    int lat, we_cnt;
    bit got, wrong;
    @(negedge clk);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    lat = 0; we_cnt = 0; got = 0; wrong = 0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_we) we_cnt++;
      if (v.port ? i_ack : d_ack) wrong = 1;
      if (v.port ? d_ack : i_ack) begin
        got = 1;
        chk($sformatf("vec%0d_rdata", idx), v.port ? d_rdata : i_rdata, v.exp_rdata);
        chk($sformatf("vec%0d_err", idx), v.port ? d_err : i_err, v.exp_err);
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk($sformatf("vec%0d_ack_latency", idx), lat, 2);
    chk($sformatf("vec%0d_mem_we_cycles", idx), we_cnt, (v.we && v.addr[1:0] == 2'b00) ? 1 : 0);
    chk($sformatf("vec%0d_other_ack", idx), wrong, 0);
    if (v.we && v.addr[1:0] == 2'b00) ref_mem[v.addr[7:2]] = v.wdata;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    int          next_edge, grant_edge, ack_edge;
    bit          m_last, m_port, m_err, m_wr;
    logic [31:0] m_rd, m_addr;
    bit          e_i_ack, e_d_ack, e_we, e_busy;
    int          n_acks;
    bit          exp_i, exp_d;

    // Reset state.
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #2;
    chk_all_zero("reset");
    full_reset();
    @(negedge clk);
    chk_all_zero("after_reset");

    // Table-driven single accesses.
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h2008_0005, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0041, 32'h1234_5678, 32'h0,         1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0042, 32'h0,         32'h0,         1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         init_val(17),  1'b0};
    for (int i = 0; i < 7; i++) do_access(vecs[i], i);

    // Reset during ACCESS of a store to 0x80.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("midop_we_in_access", mem_we, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midop_no_d_ack", d_ack, 1'b0);
    chk("midop_word80_kept", mem[32], ref_mem[32]);

    // Release reset and tie from reset: I,D,I,D every 3 cycles.
    reset_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    n_acks = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      exp_i = (n == 2) || (n == 8);
      exp_d = (n == 5) || (n == 11);
      chk($sformatf("tie_i_ack_c%0d", n), i_ack, exp_i);
      chk($sformatf("tie_d_ack_c%0d", n), d_ack, exp_d);
      if (exp_i) chk($sformatf("tie_i_rdata_c%0d", n), i_rdata, ref_mem[0]);
      if (exp_d) chk($sformatf("tie_d_rdata_c%0d", n), d_rdata, ref_mem[2]);
      if (i_ack || d_ack) n_acks++;
      if (n == 12) begin i_req = 1'b0; d_req = 1'b0; end
    end
    chk("tie_ack_count", n_acks, 4);

    // Idle: nothing happens without requests.
    repeat (2) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk($sformatf("idle_c%0d", n), {28'h0, busy, mem_we, i_ack, d_ack}, 32'h0);
    end

    // Randomized traffic against the transaction-level model.
    full_reset();
    next_edge = 0; grant_edge = -10; ack_edge = -10;
    m_last = 1'b1; m_port = 1'b0; m_err = 1'b0; m_wr = 1'b0;
    m_rd = '0; m_addr = '0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (k >= next_edge && (i_req || d_req)) begin
        m_port = (i_req && d_req) ? ~m_last : d_req;
        m_addr = m_port ? d_addr : i_addr;
        m_err  = (m_addr[1:0] != 2'b00);
        m_wr   = m_port && d_we;
        m_rd   = (m_wr || m_err) ? 32'h0 : ref_mem[m_addr[7:2]];
        if (m_wr && !m_err) ref_mem[m_addr[7:2]] = d_wdata;
        m_last = m_port;
        grant_edge = k; ack_edge = k + 1; next_edge = k + 3;
      end
      e_i_ack = (k == ack_edge) && !m_port;
      e_d_ack = (k == ack_edge) && m_port;
      e_we    = (k == grant_edge) && m_wr && !m_err;
      e_busy  = (k == grant_edge) || (k == ack_edge);
      chk("rnd_i_ack", i_ack, e_i_ack);
      chk("rnd_d_ack", d_ack, e_d_ack);
      chk("rnd_mem_we", mem_we, e_we);
      chk("rnd_busy", busy, e_busy);
      if (k == grant_edge) chk("rnd_mem_addr", mem_addr, m_addr);
      if (e_i_ack) begin
        chk("rnd_i_rdata", i_rdata, m_rd);
        chk("rnd_i_err", i_err, m_err);
      end
      if (e_d_ack) begin
        chk("rnd_d_rdata", d_rdata, m_rd);
        chk("rnd_d_err", d_err, m_err);
      end
      // Requester agents: hold until ack, then stop or issue back-to-back.
      if (e_i_ack) begin
        if ($urandom_range(0, 1) == 1) i_addr = rand_addr();
        else i_req = 1'b0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = rand_addr();
      end
      if (e_d_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified 32-bit memory (combinational read, write on rising clk when we=1) between two requesters of the multi-cycle MIPS core.
  - Port I: instruction fetch, read-only.
  - Port D: load/store, read/write.
- Sequences every access through a 3-state FSM.
- Arbitrates round-robin when both ports request in the same cycle.
- Returns a one-cycle acknowledge with registered read data.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
i_req  input  1  instruction-fetch request
i_addr  input  AW  fetch byte address
i_ack  output  1  fetch complete, one-cycle pulse
i_rdata  output  DW  fetch data, valid while i_ack=1
i_err  output  1  misaligned fetch, valid while i_ack=1
d_req  input  1  data request
d_we  input  1  1=store, 0=load
d_addr  input  AW  data byte address
d_wdata  input  DW  store data
d_ack  output  1  data access complete, one-cycle pulse
d_rdata  output  DW  load data, valid while d_ack=1 (0 for stores)
d_err  output  1  misaligned data access, valid while d_ack=1
mem_addr  output  AW  to memory addr
mem_we  output  1  to memory we
mem_wd  output  DW  to memory wd
mem_rd  input  DW  from memory rd
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State=IDLE.
  - All outputs 0, including mem_we, acks, errs, rdata, mem_addr, mem_wd.
  - Internal last_grant=D, so I wins the first tie.
- States:
  - IDLE: sample requests.
    - No request: stay in IDLE.
    - Exactly one request: grant it.
    - Both request: grant the port opposite last_grant.
    - On grant, latch port id, addr, we (0 for I) and wdata (0 for I) into registers, then go to ACCESS.
  - ACCESS (one cycle):
    - mem_addr=latched addr, mem_wd=latched wdata.
    - mem_we=latched we AND aligned, so the write commits at the clock edge ending ACCESS.
    - Capture mem_rd into the response register; capture 0 if the access is a store or misaligned.
    - Go to DONE.
  - DONE (one cycle):
    - Pulse ack (and err if misaligned) for the latched port only; its rdata is driven from the response register.
    - last_grant <= latched port. Go to IDLE.
- Aligned means addr[1:0]==2'b00. A misaligned access:
  - never asserts mem_we;
  - returns rdata=0 and err=1 with the ack.
- Latency: request sampled in IDLE at edge N → ack high during cycle N+2. One access per 3 cycles maximum.
- Handshake:
  - The requester holds req, addr, we and wdata stable from assertion until it sees ack.
  - req is ignored in ACCESS and DONE.
  - If req is still high in the IDLE cycle after ack, it is a new request (back-to-back allowed); the requester deasserts req in that cycle otherwise.
- Fairness: when both requesters hold req continuously, grants alternate I,D,I,D…; neither port waits more than one access.
- mem_addr and mem_wd hold the last latched values outside ACCESS. mem_we=0 outside ACCESS.
- rdata outputs hold their last value after ack drops; consumers use them only while ack=1.
- Reset asserted during ACCESS:
  - mem_we drops immediately, so no write is committed if reset precedes the edge.
  - No ack is issued and the pending request is lost; the requester re-issues it after reset.
- busy=1 in ACCESS and DONE.
- Address and data width: no arithmetic; addresses pass through unmodified. Word indexing is done by the memory.

Test Plan:
- Single fetch: mem word 0x0000_0004 = 0x2008_0005; i_req=1, i_addr=0x4 for one IDLE edge → i_ack=1 and i_rdata=0x2008_0005 two cycles later; d_ack stays 0.
- Store then load: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF → mem_we high for exactly one cycle, d_ack with d_rdata=0. Then a load from 0x40 → d_rdata=0xDEAD_BEEF.
- Simultaneous requests from reset: i_req and d_req held high for 12 cycles (i_addr=0x0, d_addr=0x8 load) → ack sequence I,D,I,D, each ack 3 cycles apart, 4 acks total.
- Misaligned: d_req, d_we=1, d_addr=0x41, d_wdata=0x1234_5678 → mem_we never asserts, d_ack=1, d_err=1, d_rdata=0; a subsequent load of word 0x40 returns its old value.
- Reset mid-op: store to 0x80 granted, reset_n low during ACCESS before the edge → mem_we falls immediately, no d_ack, word 0x80 unchanged, all outputs 0. After release, the first tie is granted to I.
- Idle: no requests for 10 cycles → busy=0, mem_we=0, no acks.
